// File: rtl/uart_rx_fifo.sv
// uart_rx_fifo: parametrised UART receiver with parity and framing checks that
// queues each received word and its error flags in a first-word-fall-through FIFO.
//
// state    | meaning
// ---------+------------------------------------------------------------
// S_IDLE   | line idle, waiting for a falling edge on rxS
// S_START  | waiting half a bit to confirm the start bit
// S_DATA   | sampling DATA_BITS payload bits, LSB first
// S_PARITY | sampling and checking the parity bit
// S_STOP   | sampling STOP_BITS stop bits; push on the last one
module uart_rx_fifo #(
  parameter int CLOCK_RATE = 100_000_000,
  parameter int BAUD_RATE  = 9600,
  parameter int DATA_BITS  = 8,
  parameter int PARITY     = 0,
  parameter int STOP_BITS  = 1,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                          clk,
  input  logic                          resetN,
  input  logic                          rx,
  output logic [DATA_BITS-1:0]          data,
  output logic                          parityError,
  output logic                          frameError,
  output logic                          valid,
  input  logic                          ready,
  output logic                          overrun,
  output logic [$clog2(FIFO_DEPTH):0]   count
);

  localparam int TICKS = CLOCK_RATE / BAUD_RATE;
  localparam int HALF  = TICKS / 2;
  localparam int TW    = $clog2(TICKS);
  localparam int BW    = $clog2(DATA_BITS);
  localparam int AW    = $clog2(FIFO_DEPTH);
  localparam int CW    = AW + 1;
  localparam int EW    = DATA_BITS + 2;

  typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP} state_t;

  logic rx_meta, rxS, rxS_d;

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      rx_meta <= 1'b1;
      rxS     <= 1'b1;
      rxS_d   <= 1'b1;
    end else begin
      rx_meta <= rx;
      rxS     <= rx_meta;
      rxS_d   <= rxS;
    end
  end

  state_t               state, state_n;
  logic [TW-1:0]        tick, tick_n;
  logic [BW-1:0]        bit_cnt, bit_n;
  logic [DATA_BITS-1:0] shreg, shreg_n;
  logic                 perr, perr_n, ferr, ferr_n, push;

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      state   <= S_IDLE;
      tick    <= '0;
      bit_cnt <= '0;
      shreg   <= '0;
      perr    <= 1'b0;
      ferr    <= 1'b0;
    end else begin
      state   <= state_n;
      tick    <= tick_n;
      bit_cnt <= bit_n;
      shreg   <= shreg_n;
      perr    <= perr_n;
      ferr    <= ferr_n;
    end
  end

  always_comb begin
    state_n = state;
    tick_n  = (tick == '0) ? '0 : tick - TW'(1);
    bit_n   = bit_cnt;
    shreg_n = shreg;
    perr_n  = perr;
    ferr_n  = ferr;
    push    = 1'b0;
    case (state)
      S_IDLE: begin
        if (rxS_d && !rxS) begin
          state_n = S_START;
          tick_n  = TW'(HALF - 1);
        end
      end
      S_START: begin
        if (tick == '0) begin
          if (!rxS) begin
            state_n = S_DATA;
            tick_n  = TW'(TICKS - 1);
            bit_n   = '0;
            perr_n  = 1'b0;
            ferr_n  = 1'b0;
          end else begin
            state_n = S_IDLE;
          end
        end
      end
      S_DATA: begin
        if (tick == '0) begin
          shreg_n = {rxS, shreg[DATA_BITS-1:1]};
          tick_n  = TW'(TICKS - 1);
          if (bit_cnt == BW'(DATA_BITS - 1)) begin
            bit_n   = '0;
            state_n = (PARITY != 0) ? S_PARITY : S_STOP;
          end else begin
            bit_n = bit_cnt + BW'(1);
          end
        end
      end
      S_PARITY: begin
        if (tick == '0) begin
          // odd parity wants the XOR to be 1, even wants 0
          perr_n  = (^shreg ^ rxS) ^ (PARITY == 1);
          state_n = S_STOP;
          tick_n  = TW'(TICKS - 1);
        end
      end
      S_STOP: begin
        if (tick == '0) begin
          ferr_n = ferr | !rxS;
          if (bit_cnt == BW'(STOP_BITS - 1)) begin
            push    = 1'b1;
            state_n = S_IDLE;
          end else begin
            bit_n  = bit_cnt + BW'(1);
            tick_n = TW'(TICKS - 1);
          end
        end
      end
      default: state_n = S_IDLE;
    endcase
  end

  logic [EW-1:0] mem [FIFO_DEPTH];
  logic [AW-1:0] wptr, rptr;
  logic          full, pop, wr;

  assign valid = (count != '0);
  assign full  = (count == CW'(FIFO_DEPTH));
  assign pop   = valid && ready;
  // a simultaneous pop frees the slot, so a push into a full FIFO still lands
  assign wr    = push && (!full || pop);

  always_ff @(posedge clk) begin
    if (wr) mem[wptr] <= {shreg, perr, ferr_n};
  end

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      wptr    <= '0;
      rptr    <= '0;
      count   <= '0;
      overrun <= 1'b0;
    end else begin
      wptr    <= wptr + AW'(wr);
      rptr    <= rptr + AW'(pop);
      overrun <= push && full && !pop;
      case ({wr, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  assign {data, parityError, frameError} = valid ? mem[rptr] : '0;

endmodule

// File: tb/tb_uart_rx_fifo.sv
// tb_uart_rx_fifo: drives serial frames into an 8N1 and an 8E2 receiver and
// compares the popped entries against queue-based expectations.
module tb_uart_rx_fifo;

  localparam int TICKS = 10;
  localparam int DEPTH = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       reset_a_n, rx_a, ready_a, pe_a, fe_a, valid_a, ovr_a;
  logic [7:0] data_a;
  logic [2:0] count_a;
  logic       reset_b_n, rx_b, ready_b, pe_b, fe_b, valid_b, ovr_b;
  logic [7:0] data_b;
  logic [2:0] count_b;

  uart_rx_fifo #(.CLOCK_RATE(100_000), .BAUD_RATE(9600), .DATA_BITS(8),
                 .PARITY(0), .STOP_BITS(1), .FIFO_DEPTH(DEPTH)) dut_a (
    .clk(clk), .resetN(reset_a_n), .rx(rx_a), .data(data_a), .parityError(pe_a),
    .frameError(fe_a), .valid(valid_a), .ready(ready_a), .overrun(ovr_a), .count(count_a));

  uart_rx_fifo #(.CLOCK_RATE(100_000), .BAUD_RATE(9600), .DATA_BITS(8),
                 .PARITY(2), .STOP_BITS(2), .FIFO_DEPTH(DEPTH)) dut_b (
    .clk(clk), .resetN(reset_b_n), .rx(rx_b), .data(data_b), .parityError(pe_b),
    .frameError(fe_b), .valid(valid_b), .ready(ready_b), .overrun(ovr_b), .count(count_b));

  int checks = 0;
  int errors = 0;

  logic [9:0] got_a[$], got_b[$], exp_a[$], exp_b[$];
  int ovr_a_cyc = 0, ovr_b_cyc = 0;
  int g0_a = 0, g0_b = 0, exp_ovr_a = 0, exp_ovr_b = 0;

  always @(negedge clk) begin
    if (valid_a && ready_a) got_a.push_back({data_a, pe_a, fe_a});
    if (valid_b && ready_b) got_b.push_back({data_b, pe_b, fe_b});
    if (ovr_a) ovr_a_cyc++;
    if (ovr_b) ovr_b_cyc++;
  end

  initial begin
    #50_000_000;
    $display("FAIL watchdog: simulation time limit reached, checks=%0d", checks);
    $fatal(1, "timeout");
  end

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Reference: an 8N1 frame yields {d, 0, stop_low}; dropped if FIFO holds DEPTH with ready low.
  task automatic send_a(input logic [7:0] d, input logic stop);
    if (!ready_a && (exp_a.size() - (got_a.size() - g0_a)) >= DEPTH) exp_ovr_a++;
    else exp_a.push_back({d, 1'b0, ~stop});
    rx_a = 1'b0; cyc(TICKS);
    for (int i = 0; i < 8; i++) begin rx_a = d[i]; cyc(TICKS); end
    rx_a = stop; cyc(TICKS);
    rx_a = 1'b1;
    if (!stop) cyc(TICKS);
  endtask

  // Even parity: error whenever the XOR of payload and parity bit is 1.
  task automatic send_b(input logic [7:0] d, input logic pbit, input logic s1, input logic s2);
    if (!ready_b && (exp_b.size() - (got_b.size() - g0_b)) >= DEPTH) exp_ovr_b++;
    else exp_b.push_back({d, ^{d, pbit}, ~(s1 & s2)});
    rx_b = 1'b0; cyc(TICKS);
    for (int i = 0; i < 8; i++) begin rx_b = d[i]; cyc(TICKS); end
    rx_b = pbit; cyc(TICKS);
    rx_b = s1;   cyc(TICKS);
    rx_b = s2;   cyc(TICKS);
    rx_b = 1'b1;
    if (!s2) cyc(TICKS);
  endtask

  task automatic drain_a();
    for (int i = 0; i < 600 && (got_a.size() - g0_a) < exp_a.size(); i++) cyc(1);
    cyc(5);
  endtask

  task automatic drain_b();
    for (int i = 0; i < 600 && (got_b.size() - g0_b) < exp_b.size(); i++) cyc(1);
    cyc(5);
  endtask

  task automatic start_a();
    exp_a.delete(); g0_a = got_a.size(); exp_ovr_a = 0;
  endtask

  task automatic start_b();
    exp_b.delete(); g0_b = got_b.size(); exp_ovr_b = 0;
  endtask

  task automatic test_reset();
    checks++;
    if ({valid_a, count_a, ovr_a, data_a, pe_a, fe_a} !== 14'h0) begin
      errors++; $display("FAIL reset_a: got %h expected 0", {valid_a, count_a, ovr_a, data_a, pe_a, fe_a});
    end
    checks++;
    if ({valid_b, count_b, ovr_b, data_b, pe_b, fe_b} !== 14'h0) begin
      errors++; $display("FAIL reset_b: got %h expected 0", {valid_b, count_b, ovr_b, data_b, pe_b, fe_b});
    end
  endtask

  task automatic test_back_to_back();
    int o0;
    start_a(); o0 = ovr_a_cyc; ready_a = 1'b1;
    send_a(8'h11, 1'b1); send_a(8'h22, 1'b1); send_a(8'h44, 1'b1);
    drain_a();
    checks++;
    if (got_a.size() - g0_a != exp_a.size()) begin
      errors++; $display("FAIL b2b_count: got %0d entries expected %0d", got_a.size() - g0_a, exp_a.size());
    end
    for (int i = 0; i < exp_a.size() && g0_a + i < got_a.size(); i++) begin
      checks++;
      if (got_a[g0_a + i] !== exp_a[i]) begin
        errors++; $display("FAIL b2b_entry[%0d]: got %h expected %h", i, got_a[g0_a + i], exp_a[i]);
      end
    end
    checks++;
    if (ovr_a_cyc - o0 != 0) begin
      errors++; $display("FAIL b2b_overrun: got %0d cycles expected 0", ovr_a_cyc - o0);
    end
  endtask

  task automatic test_parity();
    start_b(); ready_b = 1'b1;
    send_b(8'hA5, 1'b0, 1'b1, 1'b1);
    send_b(8'h07, 1'b0, 1'b1, 1'b1);
    drain_b();
    checks++;
    if (got_b.size() - g0_b != exp_b.size()) begin
      errors++; $display("FAIL parity_count: got %0d entries expected %0d", got_b.size() - g0_b, exp_b.size());
    end
    for (int i = 0; i < exp_b.size() && g0_b + i < got_b.size(); i++) begin
      checks++;
      if (got_b[g0_b + i] !== exp_b[i]) begin
        errors++; $display("FAIL parity_entry[%0d]: got %h expected %h", i, got_b[g0_b + i], exp_b[i]);
      end
    end
  endtask

  task automatic test_stop_bits();
    start_b(); ready_b = 1'b1;
    send_b(8'h3C, 1'b0, 1'b1, 1'b0);
    send_b(8'h55, 1'b0, 1'b1, 1'b1);
    drain_b();
    checks++;
    if (got_b.size() - g0_b != exp_b.size()) begin
      errors++; $display("FAIL stop_count: got %0d entries expected %0d", got_b.size() - g0_b, exp_b.size());
    end
    for (int i = 0; i < exp_b.size() && g0_b + i < got_b.size(); i++) begin
      checks++;
      if (got_b[g0_b + i] !== exp_b[i]) begin
        errors++; $display("FAIL stop_entry[%0d]: got %h expected %h", i, got_b[g0_b + i], exp_b[i]);
      end
    end
  endtask

  task automatic test_glitch();
    start_a(); ready_a = 1'b1;
    rx_a = 1'b0; cyc(3);
    rx_a = 1'b1; cyc(4 * TICKS);
    checks++;
    if ({valid_a, count_a} !== 4'h0) begin
      errors++; $display("FAIL glitch_count: got valid=%b count=%0d expected 0/0", valid_a, count_a);
    end
    checks++;
    if (got_a.size() != g0_a) begin
      errors++; $display("FAIL glitch_pop: got %0d pops expected 0", got_a.size() - g0_a);
    end
    send_a(8'h5A, 1'b1);
    drain_a();
    checks++;
    if (got_a.size() - g0_a != exp_a.size()) begin
      errors++; $display("FAIL glitch_after_count: got %0d entries expected %0d", got_a.size() - g0_a, exp_a.size());
    end
    for (int i = 0; i < exp_a.size() && g0_a + i < got_a.size(); i++) begin
      checks++;
      if (got_a[g0_a + i] !== exp_a[i]) begin
        errors++; $display("FAIL glitch_after_entry: got %h expected %h", got_a[g0_a + i], exp_a[i]);
      end
    end
  endtask

  task automatic test_overflow();
    int o0;
    start_a(); o0 = ovr_a_cyc; ready_a = 1'b0;
    for (int k = 1; k <= 5; k++) send_a(8'(k), 1'b1);
    cyc(2);
    checks++;
    if (count_a !== 3'(exp_a.size())) begin
      errors++; $display("FAIL ovf_count: got %0d expected %0d", count_a, exp_a.size());
    end
    checks++;
    if (ovr_a_cyc - o0 != exp_ovr_a) begin
      errors++; $display("FAIL ovf_pulse: got %0d cycles expected %0d", ovr_a_cyc - o0, exp_ovr_a);
    end
    checks++;
    if ({valid_a, data_a, pe_a, fe_a} !== {1'b1, exp_a[0]}) begin
      errors++; $display("FAIL ovf_head: got %h expected %h", {valid_a, data_a, pe_a, fe_a}, {1'b1, exp_a[0]});
    end
    ready_a = 1'b1;
    drain_a();
    checks++;
    if (got_a.size() - g0_a != exp_a.size()) begin
      errors++; $display("FAIL ovf_pops: got %0d entries expected %0d", got_a.size() - g0_a, exp_a.size());
    end
    for (int i = 0; i < exp_a.size() && g0_a + i < got_a.size(); i++) begin
      checks++;
      if (got_a[g0_a + i] !== exp_a[i]) begin
        errors++; $display("FAIL ovf_entry[%0d]: got %h expected %h", i, got_a[g0_a + i], exp_a[i]);
      end
    end
    checks++;
    if (count_a !== 3'd0) begin
      errors++; $display("FAIL ovf_empty: got %0d expected 0", count_a);
    end
  endtask

  task automatic test_reset_midframe();
    logic [7:0] d;
    d = 8'h99;
    start_a(); ready_a = 1'b0;
    send_a(8'h33, 1'b1);
    cyc(2);
    checks++;
    if (count_a !== 3'(exp_a.size())) begin
      errors++; $display("FAIL rst_prefill: got %0d expected %0d", count_a, exp_a.size());
    end
    rx_a = 1'b0; cyc(TICKS);
    for (int i = 0; i < 4; i++) begin rx_a = d[i]; cyc(TICKS); end
    rx_a = d[4]; cyc(TICKS / 2);
    reset_a_n = 1'b0; rx_a = 1'b1;
    cyc(3);
    checks++;
    if ({valid_a, count_a, ovr_a, data_a, pe_a, fe_a} !== 14'h0) begin
      errors++; $display("FAIL rst_mid_outputs: got %h expected 0", {valid_a, count_a, ovr_a, data_a, pe_a, fe_a});
    end
    reset_a_n = 1'b1;
    cyc(5);
    start_a(); ready_a = 1'b1;
    send_a(8'h66, 1'b1);
    drain_a();
    cyc(2 * TICKS);
    checks++;
    if (got_a.size() - g0_a != exp_a.size()) begin
      errors++; $display("FAIL rst_after_count: got %0d entries expected %0d", got_a.size() - g0_a, exp_a.size());
    end
    for (int i = 0; i < exp_a.size() && g0_a + i < got_a.size(); i++) begin
      checks++;
      if (got_a[g0_a + i] !== exp_a[i]) begin
        errors++; $display("FAIL rst_after_entry: got %h expected %h", got_a[g0_a + i], exp_a[i]);
      end
    end
  endtask

  task automatic test_random();
    start_a(); start_b(); ready_a = 1'b1; ready_b = 1'b1;
    for (int k = 0; k < 25; k++) begin
      send_a(8'($urandom_range(0, 255)), $urandom_range(0, 4) != 0);
      rx_a = 1'b1; cyc($urandom_range(0, 12));
    end
    for (int k = 0; k < 20; k++) begin
      send_b(8'($urandom_range(0, 255)), 1'($urandom_range(0, 1)),
             $urandom_range(0, 3) != 0, $urandom_range(0, 3) != 0);
      rx_b = 1'b1; cyc($urandom_range(0, 12));
    end
    drain_a(); drain_b();
    checks++;
    if (got_a.size() - g0_a != exp_a.size()) begin
      errors++; $display("FAIL rand_a_count: got %0d entries expected %0d", got_a.size() - g0_a, exp_a.size());
    end
    for (int i = 0; i < exp_a.size() && g0_a + i < got_a.size(); i++) begin
      checks++;
      if (got_a[g0_a + i] !== exp_a[i]) begin
        errors++; $display("FAIL rand_a_entry[%0d]: got %h expected %h", i, got_a[g0_a + i], exp_a[i]);
      end
    end
    checks++;
    if (got_b.size() - g0_b != exp_b.size()) begin
      errors++; $display("FAIL rand_b_count: got %0d entries expected %0d", got_b.size() - g0_b, exp_b.size());
    end
    for (int i = 0; i < exp_b.size() && g0_b + i < got_b.size(); i++) begin
      checks++;
      if (got_b[g0_b + i] !== exp_b[i]) begin
        errors++; $display("FAIL rand_b_entry[%0d]: got %h expected %h", i, got_b[g0_b + i], exp_b[i]);
      end
    end
  endtask

  initial begin
    reset_a_n = 1'b0; reset_b_n = 1'b0;
    rx_a = 1'b1; rx_b = 1'b1;
    ready_a = 1'b0; ready_b = 1'b0;
    cyc(3);
    test_reset();
    reset_a_n = 1'b1; reset_b_n = 1'b1;
    cyc(3);
    test_back_to_back();
    test_parity();
    test_stop_bits();
    test_glitch();
    test_overflow();
    test_reset_midframe();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
